lfsr_gen: RTL and testbench
===========================

# lfsr_gen

Parametrised maximal-length LFSR generator, the successor to the fixed 20-bit LFSR: width selectable from 3 to 32 bits, runtime Fibonacci/Galois mode, seed loading with all-zero lock-up protection, and multi-step (leapfrog) advance per clock. It serves as the shared pseudo-random source for the team's test-pattern generators, scramblers and self-test counters. A registered `max_tick` marks each completed period.

## Interface
Parameters:
- `WIDTH`, 20: register width, legal 3..32; polynomial taken from the package tap table.
- `STEP`, 1: single-step advances per enabled clock, legal 1..WIDTH.
- `SEED`, 1: reset value and substitute seed; must be non-zero.
- `MODE_RST`, 0: mode after reset; 0 = Fibonacci, 1 = Galois.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance enable.
- `load`  in  1  load `seed_in` and `mode`; has priority over `en`.
- `mode`  in  1  generator form, sampled only when `load`=1.
- `seed_in`  in  WIDTH  seed value.
- `Q_out`  out  WIDTH  current LFSR state.
- `max_tick`  out  1  one-cycle pulse when `Q_out` returns to the origin.
- `seed_err`  out  1  one-cycle pulse when a zero seed was substituted.

## Operation
- Tap mask T comes from `lfsr_pkg` (e.g. W=4: 4'b1100; W=20: 20'h90000).
- Fibonacci step: Q' = {Q[W-2:0], ^(Q & T)}.
- Galois step: G = {T[W-2:0], 1'b1}; Q' = (Q << 1) ^ (Q[W-1] ? G : 0), truncated to W bits.
- Per enabled clock, STEP single steps are applied in the active mode.
- Internal state: `Q`, `origin` (WIDTH), `mode_r`.
- Priority: `rst` > `load` > `en` > hold.
- `load`: Q ← `seed_in` (or `SEED` if `seed_in`==0), origin ← same value, mode_r ← `mode`. Next cycle `seed_err`=1 when substitution occurred, `max_tick`=0.
- `en`=1, `load`=0: Q ← Q advanced STEP steps. `max_tick` is registered and equals 1 in the cycle where the new `Q_out` equals `origin`.
- `en`=0: Q holds; `max_tick`=0.
- All-zero state is unreachable: reset, load and stepping never produce it.
- Period in enabled clocks: (2^W−1)/gcd(2^W−1, STEP).

## Timing
- Reset values: `Q_out`=`SEED`, origin=`SEED`, mode_r=`MODE_RST`, `max_tick`=0, `seed_err`=0.
- Latency: one clock from `en`/`load` sample to updated `Q_out`. `max_tick` and `seed_err` are aligned with that `Q_out`.
- Reset mid-sequence: immediate asynchronous return to reset values; counting restarts from `SEED`.
- `load` and `en` in the same cycle: the load wins and no advance occurs that cycle.
- Loading the value currently in Q: no `max_tick` is produced.
- Back-to-back loads are allowed; every load restarts the period.
- A `mode` change without `load` has no effect.

## Structure
- `lfsr_pkg`: function `lfsr_taps(width)` returning the maximal-length mask for widths 3..32, and the mode constants `LFSR_FIB`/`LFSR_GAL`.
- Sub-module `lfsr_step`: one combinational single step, parametrised on WIDTH, with a mode input. Instantiate STEP of them in a generate chain.
- Top level holds the registers, load/seed-substitution logic and origin compare.

## Test plan
- W=4, STEP=1, Fibonacci, after reset: `Q_out` sequence is 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000,0001. `max_tick`=1 only alongside the final 0001.
- W=4, STEP=1, load `mode`=1, `seed_in`=0001: sequence is 0010,0100,1000,1001,1011,1111,0111,1110,0101,1010,1101,0011,0110,1100,0001. `max_tick` pulses every 15 enabled clocks.
- W=4, STEP=3, Fibonacci from 0001: second state 1001. `max_tick` pulses every 5 enabled clocks.
- Load with `seed_in`=0: next cycle `Q_out`=`SEED`, `seed_err`=1 for exactly one cycle.
- `en` toggled randomly, W=20: all 2^20−1 states are visited once before `max_tick`. No pulse occurs while `en`=0.
- Assert `rst` mid-sequence, and `load`+`en` together: `Q_out` goes immediately to `SEED` on reset. On load+en, `Q_out` equals the loaded seed, not its successor.

Source files
------------

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - tap table and mode constants shared by the LFSR generator
package lfsr_pkg;

  // Generator form; the value matches the encoding of the mode port
  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  // Maximal-length tap mask for widths 3..32, bit k set means stage k+1 is tapped.
  // Illegal widths return zero so a bad WIDTH shows up as a stuck generator.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - one combinational LFSR advance in Fibonacci or Galois form
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 20,
  parameter logic [WIDTH-1:0] TAPS  = '0
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  // Galois toggle pattern: the tap mask shifted up, with the feedback landing in bit 0
  localparam logic [WIDTH-1:0] GAL_MASK = {TAPS[WIDTH-2:0], 1'b1};

  logic             fib_fb;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;

  assign fib_fb   = ^(q & TAPS);
  assign fib_next = {q[WIDTH-2:0], fib_fb};
  assign gal_next = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? GAL_MASK : '0);

  // Select the active form
  always_comb begin
    q_next = fib_next;
    if (mode == LFSR_GAL) q_next = gal_next;
  end

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - maximal-length LFSR with seed load, runtime mode and leapfrog stepping
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 20,
  parameter int               STEP     = 1,
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(1),
  parameter logic             MODE_RST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] Q_out,
  output logic             max_tick,
  output logic             seed_err
);

  localparam logic [31:0]      TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] origin;
  lfsr_mode_e       mode_r;
  logic [WIDTH-1:0] q_adv;
  logic             seed_zero;
  logic [WIDTH-1:0] seed_val;

  // A zero seed would lock the register up, so it is replaced by SEED
  assign seed_zero = (seed_in == '0);
  assign seed_val  = seed_zero ? SEED : seed_in;

  // Chain of STEP single-step stages; each stage feeds the next
  for (genvar i = 0; i < STEP; i++) begin : stage
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    if (i == 0) begin : g_first
      assign cur = q;
    end else begin : g_rest
      assign cur = stage[i-1].nxt;
    end
    lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_step (
      .mode   (mode_r),
      .q      (cur),
      .q_next (nxt)
    );
  end

  assign q_adv = stage[STEP-1].nxt;

  // State update with priority reset > load > advance > hold; pulses are registered with Q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= SEED;
      origin   <= SEED;
      mode_r   <= lfsr_mode_e'(MODE_RST);
      max_tick <= 1'b0;
      seed_err <= 1'b0;
    end else if (load) begin
      q        <= seed_val;
      origin   <= seed_val;
      mode_r   <= lfsr_mode_e'(mode);
      max_tick <= 1'b0;
      seed_err <= seed_zero;
    end else if (en) begin
      q        <= q_adv;
      max_tick <= (q_adv == origin);
      seed_err <= 1'b0;
    end else begin
      max_tick <= 1'b0;
      seed_err <= 1'b0;
    end
  end

  assign Q_out = q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - scoreboard bench for lfsr_gen in W=4 (STEP 1 and 3) and W=20 builds
module tb_lfsr_gen;

  typedef struct {
    logic [31:0] q;
    logic        tick;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       en_a = 0, load_a = 0, mode_a = 0;
  logic [3:0] seed_a = '0;
  logic [3:0] q_a;
  logic       tick_a, err_a;

  logic       en_b = 0, load_b = 0, mode_b = 0;
  logic [3:0] seed_b = '0;
  logic [3:0] q_b;
  logic       tick_b, err_b;

  logic        en_c = 0, load_c = 0, mode_c = 0;
  logic [19:0] seed_c = '0;
  logic [19:0] q_c;
  logic        tick_c, err_c;

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  logic [3:0] fib4 [0:14];
  logic [3:0] gal4 [0:14];
  logic [3:0] st3  [0:4];

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(4), .STEP(1), .SEED(4'h1), .MODE_RST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .load(load_a), .mode(mode_a),
    .seed_in(seed_a), .Q_out(q_a), .max_tick(tick_a), .seed_err(err_a));

  lfsr_gen #(.WIDTH(4), .STEP(3), .SEED(4'h1), .MODE_RST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .load(load_b), .mode(mode_b),
    .seed_in(seed_b), .Q_out(q_b), .max_tick(tick_b), .seed_err(err_b));

  lfsr_gen #(.WIDTH(20), .STEP(1), .SEED(20'h1), .MODE_RST(1'b0)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .load(load_c), .mode(mode_c),
    .seed_in(seed_c), .Q_out(q_c), .max_tick(tick_c), .seed_err(err_c));

  task automatic check_item(input string name, input logic [31:0] gq, input logic gt,
                            input logic ge, input exp_t e);
    checks++;
    if (gq !== e.q || gt !== e.tick || ge !== e.err) begin
      errors++;
      $display("FAIL %s: got q=%h tick=%b err=%b, expected q=%h tick=%b err=%b",
               name, gq, gt, ge, e.q, e.tick, e.err);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] q, input logic t, input logic e);
    exp_t r;
    r.q = q; r.tick = t; r.err = e;
    return r;
  endfunction

  // Monitor: pops one expectation per DUT for every clock that had stimulus issued
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) check_item("a", {28'b0, q_a}, tick_a, err_a, qa.pop_front());
    if (qb.size() > 0) check_item("b", {28'b0, q_b}, tick_b, err_b, qb.pop_front());
    if (qc.size() > 0) check_item("c", {12'b0, q_c}, tick_c, err_c, qc.pop_front());
  end

  task automatic drive_a(input logic en, input logic ld, input logic md, input logic [3:0] sd,
                         input logic [3:0] eq, input logic et, input logic ee);
    @(negedge clk);
    en_a = en; load_a = ld; mode_a = md; seed_a = sd;
    qa.push_back(mk({28'b0, eq}, et, ee));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [19:0] m_c;
    fib4 = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101,
             4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
    gal4 = '{4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b1011, 4'b1111, 4'b0111, 4'b1110,
             4'b0101, 4'b1010, 4'b1101, 4'b0011, 4'b0110, 4'b1100, 4'b0001};
    st3  = '{4'b1001, 4'b1101, 4'b1011, 4'b1110, 4'b0001};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_item("rst_a", {28'b0, q_a}, tick_a, err_a, mk(32'h1, 1'b0, 1'b0));
    check_item("rst_b", {28'b0, q_b}, tick_b, err_b, mk(32'h1, 1'b0, 1'b0));
    check_item("rst_c", {12'b0, q_c}, tick_c, err_c, mk(32'h1, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;

    // Full Fibonacci period from reset
    for (int i = 0; i < 15; i++) drive_a(1, 0, 0, 4'h0, fib4[i], i == 14, 0);
    // Hold while disabled
    drive_a(0, 0, 0, 4'h0, 4'b0001, 0, 0);
    drive_a(0, 0, 0, 4'h0, 4'b0001, 0, 0);
    // Load current value together with en, switching to Galois: no advance, no tick
    drive_a(1, 1, 1, 4'b0001, 4'b0001, 0, 0);
    // Two Galois periods
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 15; i++) drive_a(1, 0, 1, 4'h0, gal4[i], i == 14, 0);
    // Mode port change without load is ignored
    for (int i = 0; i < 3; i++) drive_a(1, 0, 0, 4'h0, gal4[i], 0, 0);
    // Zero seed is substituted, error pulses for one cycle
    drive_a(0, 1, 0, 4'h0, 4'b0001, 0, 1);
    drive_a(0, 0, 0, 4'h0, 4'b0001, 0, 0);
    drive_a(1, 0, 0, 4'h0, 4'b0010, 0, 0);
    drive_a(1, 0, 0, 4'h0, 4'b0100, 0, 0);
    // Explicit load, advance, back-to-back loads
    drive_a(0, 1, 0, 4'b1010, 4'b1010, 0, 0);
    drive_a(1, 0, 0, 4'h0, 4'b0101, 0, 0);
    drive_a(0, 1, 0, 4'b0110, 4'b0110, 0, 0);
    drive_a(0, 1, 1, 4'b0011, 4'b0011, 0, 0);
    drive_a(1, 0, 0, 4'h0, 4'b0110, 0, 0);
    drive_a(1, 0, 0, 4'h0, 4'b1100, 0, 0);
    drive_a(0, 0, 0, 4'h0, 4'b1100, 0, 0);

    // Asynchronous reset mid-sequence, visible before the next clock edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_item("async_rst_a", {28'b0, q_a}, tick_a, err_a, mk(32'h1, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    // Counting restarts from SEED in the reset mode (Fibonacci)
    drive_a(1, 0, 0, 4'h0, 4'b0010, 0, 0);
    drive_a(1, 0, 0, 4'h0, 4'b0100, 0, 0);
    drive_a(1, 0, 0, 4'h0, 4'b1001, 0, 0);
    drive_a(0, 0, 0, 4'h0, 4'b1001, 0, 0);

    // Leapfrog by 3: period of 5 enabled clocks
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en_b = 1'b1;
      qb.push_back(mk({28'b0, st3[i % 5]}, (i % 5) == 4, 1'b0));
    end
    @(negedge clk);
    en_b = 1'b0;
    qb.push_back(mk(32'h1, 1'b0, 1'b0));

    // W=20 with random enable against a bench model; no tick may appear
    m_c = 20'h1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      en_c = 1'($urandom_range(0, 1));
      if (en_c) m_c = {m_c[18:0], m_c[19] ^ m_c[16]};
      qc.push_back(mk({12'b0, m_c}, 1'b0, 1'b0));
    end
    @(negedge clk);
    en_c = 1'b0;

    // Bounded drain of the scoreboard
    repeat (3) @(posedge clk);
    #2;
    if (qa.size() + qb.size() + qc.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never checked, expected 0",
               qa.size() + qb.size() + qc.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
